// File: rtl/btn_sched_pkg.sv
// rtl/btn_sched_pkg.sv - shared types and defaults for the button command scheduler
package btn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    localparam int DEF_N_BTN   = 4;
    localparam int DEF_GAP_CYC = 16;
    localparam int DEF_REP_DLY = 1000000;
    localparam int DEF_REP_PER = 250000;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_cmd_sched_rr_arbiter.sv
// rtl/btn_cmd_sched_rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import btn_sched_pkg::*;
#(
    parameter int N    = DEF_N_BTN,
    parameter int ID_W = id_w(DEF_N_BTN)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_valid,
    output logic [ID_W-1:0] gnt_id
);

    logic [N-1:0]  rot;
    logic [ID_W:0] sum;

    // Rotate so the pointer sits at bit 0, then the lowest set bit is the winner.
    always_comb begin
        rot       = N'({req, req} >> ptr);
        gnt_valid = 1'b0;
        sum       = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                gnt_valid = 1'b1;
                sum       = {1'b0, ptr} + (ID_W + 1)'(j);
            end
        end
        if (sum >= (ID_W + 1)'(N)) begin
            sum = sum - (ID_W + 1)'(N);
        end
        gnt_id = sum[ID_W-1:0];
    end

endmodule

// File: rtl/btn_cmd_sched.sv
// rtl/btn_cmd_sched.sv - press latch, round-robin command issue and post-command gap; AUTO_REPEAT_EN adds held-button repeat
module btn_cmd_sched
    import btn_sched_pkg::*;
#(
    parameter int N_BTN   = DEF_N_BTN,
    parameter int GAP_CYC = DEF_GAP_CYC,
    parameter int REP_DLY = DEF_REP_DLY,
    parameter int REP_PER = DEF_REP_PER
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_BTN-1:0]       btn_pulse,
    input  logic [N_BTN-1:0]       btn_level,
    output logic                   cmd_valid,
    output logic [id_w(N_BTN)-1:0] cmd_id,
    input  logic                   cmd_ready,
    output logic [N_BTN-1:0]       pending,
    output logic                   drop_flag
);

    localparam int ID_W = id_w(N_BTN);
    localparam int GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    sched_state_t    state_q, state_d;
    logic [ID_W-1:0] cmd_id_q, id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [N_BTN-1:0] pending_q, press, clr, rep_fire;
    logic            drop_q, handshake, gnt_valid;
    logic [ID_W-1:0] gnt_id;

    rr_arbiter #(.N(N_BTN), .ID_W(ID_W)) u_arb (
        .req      (pending_q),
        .ptr      (ptr_q),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id)
    );

`ifdef AUTO_REPEAT_EN
    localparam int DW = (REP_DLY > 0) ? $clog2(REP_DLY + 1) : 1;
    localparam int PW = (REP_PER > 1) ? $clog2(REP_PER) : 1;

    logic [DW-1:0] dly_q [N_BTN];
    logic [PW-1:0] per_q [N_BTN];

    // dly_q saturates at REP_DLY; per_q then cycles through the repeat period.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_BTN; i++) begin
            if (reset || !btn_level[i]) begin
                dly_q[i] <= '0;
                per_q[i] <= '0;
            end else if (dly_q[i] != DW'(REP_DLY)) begin
                dly_q[i] <= dly_q[i] + 1'b1;
            end else if (per_q[i] == PW'(REP_PER - 1)) begin
                per_q[i] <= '0;
            end else begin
                per_q[i] <= per_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rep_fire[i] = btn_level[i] && (dly_q[i] == DW'(REP_DLY)) && (per_q[i] == '0);
        end
    end
`else
    logic unused_level;
    assign unused_level = ^btn_level;
    assign rep_fire     = '0;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = cmd_id_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        handshake = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = ISSUE;
                    id_d    = gnt_id;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    handshake = 1'b1;
                    ptr_d     = (cmd_id_q == ID_W'(N_BTN - 1)) ? '0 : cmd_id_q + 1'b1;
                    gap_d     = '0;
                    state_d   = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A press landing on its own clear cycle is kept and is not a drop.
    assign press = btn_pulse | rep_fire;
    assign clr   = handshake ? (N_BTN'(1) << cmd_id_q) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_id_q  <= '0;
            ptr_q     <= '0;
            gap_q     <= '0;
            pending_q <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_id_q  <= id_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            pending_q <= (pending_q & ~clr) | press;
            drop_q    <= drop_q | (|(press & pending_q & ~clr));
        end
    end

    assign cmd_valid = (state_q == ISSUE);
    assign cmd_id    = cmd_id_q;
    assign pending   = pending_q;
    assign drop_flag = drop_q;

endmodule

// File: tb/tb_btn_cmd_sched.sv
// tb/tb_btn_cmd_sched.sv - randomized and directed bench for btn_cmd_sched against a cycle-level reference model
module tb_btn_cmd_sched;

    localparam int N   = 4;
    localparam int IW  = 2;
    localparam int GAP = 16;
    localparam int RD  = 20;
    localparam int RP  = 5;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [N-1:0]  btn_pulse = '0;
    logic [N-1:0]  btn_level = '0;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [IW-1:0] cmd_id;
    logic [N-1:0]  pending;
    logic          drop_flag;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending set, whether a command is on offer, cooldown after acceptance.
    bit m_pend [N];
    bit m_off;
    int m_id;
    int m_ptr;
    int m_cool;
    bit m_drop;
    int m_held [N];
    int hs_ids [$];

    btn_cmd_sched #(.N_BTN(N), .GAP_CYC(GAP), .REP_DLY(RD), .REP_PER(RP)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level),
        .cmd_valid(cmd_valid),
        .cmd_id   (cmd_id),
        .cmd_ready(cmd_ready),
        .pending  (pending),
        .drop_flag(drop_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [N+IW+1:0] exp_vec();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        return {m_off, m_off ? IW'(m_id) : IW'(0), p, m_drop};
    endfunction

    function automatic logic [N+IW+1:0] obs_vec();
        return {cmd_valid, cmd_valid ? cmd_id : IW'(0), pending, drop_flag};
    endfunction

    task automatic step();
        bit fire [N];
        bit hs;
        int pick;
        int acc_id;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_held[i] = 0;
            end
            m_off = 0; m_id = 0; m_ptr = 0; m_cool = 0; m_drop = 0;
        end else begin
            hs     = m_off && cmd_ready;
            acc_id = m_id;
            for (int i = 0; i < N; i++) begin
                fire[i] = btn_pulse[i];
`ifdef AUTO_REPEAT_EN
                if (btn_level[i] && m_held[i] >= RD && ((m_held[i] - RD) % RP) == 0) fire[i] = 1;
`endif
            end
            pick = -1;
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && m_pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
            if (hs) begin
                m_off  = 0;
                m_cool = GAP;
                m_ptr  = (acc_id + 1) % N;
                hs_ids.push_back(acc_id);
            end else if (!m_off) begin
                if (m_cool > 0) m_cool--;
                else if (pick >= 0) begin
                    m_off = 1;
                    m_id  = pick;
                end
            end
            for (int i = 0; i < N; i++) begin
                bit clr;
                clr = hs && (acc_id == i);
                if (fire[i] && m_pend[i] && !clr) m_drop = 1;
                m_pend[i] = (m_pend[i] && !clr) || fire[i];
                m_held[i] = btn_level[i] ? m_held[i] + 1 : 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; btn_pulse = '0; cmd_ready = 0;
        step(); step();
        vectors++;
        if ({cmd_valid, cmd_id, pending, drop_flag} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b id=%0d p=%b d=%b, want all zero", cmd_valid, cmd_id, pending, drop_flag);
        end
        reset = 0; btn_pulse = 4'b0100; step();
        btn_pulse = '0; step();
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL reset_pre_issue: got %h want %h", obs_vec(), exp_vec());
        end
        btn_pulse = 4'b0100; step();
        btn_pulse = '0;
        reset = 1; step(); reset = 0;
        vectors++;
        if (cmd_valid !== 1'b0 || pending !== '0 || drop_flag !== 1'b0 || cmd_id !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_issue: got v=%b id=%0d p=%b d=%b, want 0/0/0000/0", cmd_valid, cmd_id, pending, drop_flag);
        end
    endtask

    task automatic test_single_press();
        int low;
        reset = 1; step(); reset = 0;
        cmd_ready = 1; btn_pulse = 4'b0001; step();
        btn_pulse = '0;
        vectors++;
        if (obs_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL single_lat1: got %h want %h", obs_vec(), exp_vec());
        end
        step();
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_lat2: got v=%b id=%0d want v=1 id=0", cmd_valid, cmd_id);
        end
        btn_pulse = 4'b0001; step();
        btn_pulse = '0;
        low = 0;
        for (int c = 0; c < 40 && cmd_valid !== 1'b1; c++) begin
            low++;
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL single_gap_state: got %h want %h", obs_vec(), exp_vec());
            end
            step();
        end
        vectors++;
        if (low != GAP + 1) begin
            miscompares++;
            $display("FAIL single_gap_len: got %0d low cycles want %0d", low, GAP + 1);
        end
    endtask

    task automatic test_round_robin();
        int start;
        reset = 1; step(); reset = 0;
        cmd_ready = 1; btn_pulse = 4'b1111; step();
        btn_pulse = '0;
        start = hs_ids.size();
        for (int c = 0; c < 200 && hs_ids.size() - start < 4; c++) begin
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rr_cycle: got %h want %h", obs_vec(), exp_vec());
            end
            step();
        end
        vectors++;
        if (hs_ids.size() - start != 4) begin
            miscompares++;
            $display("FAIL rr_count: got %0d grants want 4", hs_ids.size() - start);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (hs_ids[start + i] != i) begin
                    miscompares++;
                    $display("FAIL rr_order: grant %0d got id %0d want %0d", i, hs_ids[start + i], i);
                end
            end
        end
        vectors++;
        if (pending !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_pending: got %b want 0000", pending);
        end
    endtask

    task automatic test_backpressure();
        reset = 1; step(); reset = 0;
        cmd_ready = 0; btn_pulse = 4'b1000; step();
        btn_pulse = '0; step();
        for (int c = 0; c < 50; c++) begin
            step();
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd3) begin
                miscompares++;
                $display("FAIL bp_hold: cycle %0d got v=%b id=%0d want v=1 id=3", c, cmd_valid, cmd_id);
            end
        end
        cmd_ready = 1; step();
        cmd_ready = 0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (cmd_valid !== 1'b0 || pending !== 4'b0000 || obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL bp_release: got v=%b p=%b want v=0 p=0000", cmd_valid, pending);
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        reset = 1; step(); reset = 0;
        cmd_ready = 0; btn_pulse = 4'b0100; step();
        btn_pulse = '0; step();
        cmd_ready = 1; btn_pulse = 4'b0100; step();
        cmd_ready = 0; btn_pulse = '0;
        vectors++;
        if (pending[2] !== 1'b1 || drop_flag !== 1'b0 || cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_keep: got p2=%b d=%b v=%b want p2=1 d=0 v=0", pending[2], drop_flag, cmd_valid);
        end
        btn_pulse = 4'b0100; step();
        btn_pulse = '0;
        vectors++;
        if (drop_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_drop: got d=%b want 1", drop_flag);
        end
        reset = 1; step(); reset = 0;
    endtask

`ifdef AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        int first;
        reset = 1; step(); reset = 0;
        cmd_ready = 1; btn_level = 4'b0010; first = -1;
        for (int j = 1; j <= 40; j++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL rep_cycle: held %0d got %h want %h", j, obs_vec(), exp_vec());
            end
            if (first < 0 && pending[1] === 1'b1) first = j;
        end
        btn_level = '0;
        vectors++;
        if (first != RD + 1) begin
            miscompares++;
            $display("FAIL rep_first: got first press after %0d cycles want %0d", first, RD + 1);
        end
    endtask
`endif

    task automatic test_random();
        reset = 1; step(); reset = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                btn_pulse[i] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 29) == 0) btn_level[i] = ~btn_level[i];
            end
            cmd_ready = ($urandom_range(0, 2) != 0);
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random: cycle %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        reset = 0; btn_pulse = '0; btn_level = '0; cmd_ready = 0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single_press();
        test_round_robin();
        test_backpressure();
        test_simultaneous();
`ifdef AUTO_REPEAT_EN
        test_auto_repeat();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
